// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiation (left-to-right square-and-multiply) driving an external divider.
// Optional build macro: MODEXP_SKIP_LEADING_ZEROS_EN skips squarings for the exponent's leading zero bits.
module mod_exp_seq #(
  parameter int unsigned K = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K-1:0]   base,
  input  logic [K-1:0]   exp,
  input  logic [K-1:0]   modulus,
  output logic           busy,
  output logic           done,
  output logic [K-1:0]   result,
  output logic           err,
  output logic           div_req,
  output logic [2*K-1:0] div_a,
  output logic [2*K-1:0] div_b,
  input  logic           div_ack,
  input  logic [2*K-1:0] div_rem
);

  localparam int unsigned W2 = 2 * K;
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RED,
    SQR,
    MUL,
    NEXT,
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    SKIP,
`endif
    DONE
  } state_t;

  state_t          state, state_d;
  logic [K-1:0]    exp_q, exp_d;
  logic [K-1:0]    b_q, b_d;
  logic [K-1:0]    r_q, r_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_d, done_d, busy_d, div_req_d;
  logic [K-1:0]    result_d;
  logic [W2-1:0]   div_a_d, div_b_d;
  logic [K-1:0]    mul_b;
  logic [W2-1:0]   prod;
  logic            ack_ok;
  logic            unused_rem_hi;

  // Only the low K bits of the remainder can be nonzero since the divisor fits in K bits.
  assign unused_rem_hi = ^div_rem[W2-1:K];

  // An ack in the request cycle cannot belong to the request just issued.
  assign ack_ok = div_ack && !div_req;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state;
    exp_d    = exp_q;
    b_d      = b_q;
    r_d      = r_q;
    idx_d    = idx_q;
    err_d    = err;
    result_d = result;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          exp_d = exp;
          r_d   = K'(1);
          idx_d = IW'(K - 1);
          err_d = 1'b0;
          if (modulus == '0) begin
            err_d   = 1'b1;
            r_d     = '0;
            state_d = DONE;
          end else begin
            state_d = RED;
          end
        end
      end
      RED: begin
        if (ack_ok) begin
          b_d     = div_rem[K-1:0];
          state_d = SQR;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          if (exp_q == '0) begin
            r_d     = (div_b == W2'(1)) ? '0 : K'(1);
            state_d = DONE;
          end else if (!exp_q[idx_q]) begin
            state_d = SKIP;
          end
`endif
        end
      end
      SQR: begin
        if (ack_ok) begin
          r_d     = div_rem[K-1:0];
          state_d = exp_q[idx_q] ? MUL : NEXT;
        end
      end
      MUL: begin
        if (ack_ok) begin
          r_d     = div_rem[K-1:0];
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = SQR;
        end
      end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      // One cycle per leading zero; r is still 1 so the skipped squarings are identities.
      SKIP: begin
        idx_d = idx_q - IW'(1);
        if (exp_q[idx_d]) begin
          state_d = SQR;
        end
      end
`endif
      DONE: begin
        result_d = r_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider request and operands, loaded only on entry to a wait state and held until the ack.
  always_comb begin
    busy_d    = (state_d != IDLE);
    div_req_d = (state_d inside {RED, SQR, MUL}) && (state_d != state);
    mul_b     = (state_d == MUL) ? b_d : r_d;
    prod      = W2'(r_d) * W2'(mul_b);
    div_a_d   = div_a;
    div_b_d   = div_b;
    if (div_req_d) begin
      if (state_d == RED) begin
        div_a_d = W2'(base);
        div_b_d = W2'(modulus);
      end else begin
        div_a_d = prod;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      exp_q   <= '0;
      b_q     <= '0;
      r_q     <= '0;
      idx_q   <= IW'(K - 1);
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      div_req <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
    end else begin
      state   <= state_d;
      exp_q   <= exp_d;
      b_q     <= b_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      result  <= result_d;
      div_req <= div_req_d;
      div_a   <= div_a_d;
      div_b   <= div_b_d;
    end
  end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Directed and randomized checks of mod_exp_seq against a right-to-left exponentiation model
// and a 3-cycle behavioural divider.
module tb_mod_exp_seq;

  localparam int unsigned K = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [K-1:0]  base = '0;
  logic [K-1:0]  exp_v = '0;
  logic [K-1:0]  modulus = '0;
  logic          busy, done, err, div_req;
  logic [K-1:0]  result;
  logic [63:0]   div_a, div_b;
  logic [63:0]   div_rem = '0;
  logic          div_ack;
  logic          ack_m = 1'b0;
  logic          ack_spur = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned req_total = 0;
  int unsigned done_total = 0;
  int unsigned div_cnt = 0;
  logic [63:0] la = '0, lb = '0;

  assign div_ack = ack_m | ack_spur;

  always #5 clk = ~clk;

  mod_exp_seq #(.K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp_v), .modulus(modulus),
    .busy(busy), .done(done), .result(result), .err(err),
    .div_req(div_req), .div_a(div_a), .div_b(div_b), .div_ack(div_ack), .div_rem(div_rem)
  );

  // Behavioural divider: acks three cycles after each request; also counts requests and done pulses.
  always @(negedge clk) begin
    ack_m = 1'b0;
    if (div_cnt != 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        ack_m   = 1'b1;
        div_rem = (lb == 0) ? 64'd0 : la % lb;
      end
    end
    if (div_req) begin
      req_total++;
      div_cnt = 3;
      la = div_a;
      lb = div_b;
    end
    if (done) done_total++;
  end

  function automatic longint unsigned ref_modexp(input longint unsigned b, input longint unsigned e,
                                                 input longint unsigned n);
    longint unsigned r;
    if (n == 0) return 0;
    r = 1 % n;
    b = b % n;
    while (e != 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned ref_reqs(input logic [K-1:0] e, input logic [K-1:0] n);
    int unsigned pop;
    int msb;
    if (n == 0) return 0;
    pop = $countones(e);
    msb = -1;
    for (int i = 0; i < K; i++) if (e[i]) msb = i;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    if (e == 0) return 1;
    return 1 + (msb + 1) + pop;
`else
    return 1 + K + pop;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run(input logic [K-1:0] b, input logic [K-1:0] e, input logic [K-1:0] n,
                     input bit disturb, input string tag, output int lat);
    int unsigned r0, d0, exp_req;
    longint unsigned exp_res;
    bit seen;
    exp_res = ref_modexp(longint'(b), longint'(e), longint'(n));
    exp_req = ref_reqs(e, n);
    @(negedge clk);
    r0 = req_total;
    d0 = done_total;
    base = b; exp_v = e; modulus = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      repeat (4) @(negedge clk);
      base = ~b; exp_v = ~e; modulus = n + 3; start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    lat = 0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat = c;
      end
    end
    check($sformatf("%s_done_seen", tag), 64'(seen), 64'd1);
    check($sformatf("%s_result", tag), 64'(result), exp_res);
    check($sformatf("%s_err", tag), 64'(err), 64'(n == 0));
    repeat (3) @(negedge clk);
    check($sformatf("%s_done_pulses", tag), 64'(done_total - d0), 64'd1);
    check($sformatf("%s_div_reqs", tag), 64'(req_total - r0), 64'(exp_req));
    check($sformatf("%s_idle_busy", tag), 64'(busy), 64'd0);
    if (disturb) begin
      ack_spur = 1'b1;
      repeat (4) @(negedge clk);
      ack_spur = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("%s_spur_result", tag), 64'(result), exp_res);
      check($sformatf("%s_spur_reqs", tag), 64'(req_total - r0), 64'(exp_req));
      check($sformatf("%s_spur_done", tag), 64'(done_total - d0), 64'd1);
      check($sformatf("%s_spur_busy", tag), 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int lat;
    int unsigned r0, d0;
    bit hit;
    logic [K-1:0] rb, re, rn;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_div_req", 64'(div_req), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_div_a", div_a, 64'd0);
    check("rst_div_b", div_b, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(32'd4, 32'd13, 32'd497, 1'b0, "pow_4_13_497", lat);
    check("pow_4_13_497_const", 64'(result), 64'd445);
    run(32'd1000, 32'd1, 32'd7, 1'b0, "base_ge_mod", lat);
    check("base_ge_mod_const", 64'(result), 64'd6);
    run(32'd123, 32'd456, 32'd0, 1'b0, "mod_zero", lat);
    check("mod_zero_latency", 64'(lat), 64'd0);
    run(32'd9, 32'd0, 32'd5, 1'b0, "exp_zero", lat);
    check("exp_zero_const", 64'(result), 64'd1);
    run(32'd77, 32'd0, 32'd1, 1'b0, "exp_zero_mod_one", lat);
    run(32'd12345, 32'hFFFF_FFFF, 32'd1, 1'b0, "mod_one", lat);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "all_ones", lat);
    run(32'hFFFF_FFFE, 32'h8000_0001, 32'hFFFF_FFFB, 1'b0, "wide", lat);
    run(32'd2, 32'd10, 32'd1000, 1'b1, "disturb", lat);

    // Reset during the first SQR wait, with the aborted divider ack arriving afterwards
    @(negedge clk);
    r0 = req_total;
    d0 = done_total;
    base = 32'd5; exp_v = 32'd77; modulus = 32'd101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (req_total - r0 >= 2) hit = 1'b1;
    end
    check("midrst_reached_sqr", 64'(hit), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_div_req", 64'(div_req), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_div_a", div_a, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_busy_after", 64'(busy), 64'd0);
    check("midrst_no_done", 64'(done_total - d0), 64'd0);
    check("midrst_result_after", 64'(result), 64'd0);
    run(32'd3, 32'd5, 32'd7, 1'b0, "after_rst", lat);
    check("after_rst_const", 64'(result), 64'd5);

    // Randomized operands: alternate small and full-width moduli
    for (int t = 0; t < 6; t++) begin
      rb = $urandom;
      re = (t == 2) ? K'($urandom_range(1, 255)) : K'($urandom);
      rn = t[0] ? K'($urandom_range(1, 65535)) : K'($urandom | 1);
      run(rb, re, rn, 1'b0, $sformatf("rand%0d", t), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_exp_seq.md
MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

Interface
REQ-001 SHALL have parameter K, default 32, giving base/exponent/modulus width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports base, exp, modulus  input  K each  operands, sampled only when a start is accepted.
REQ-005 SHALL have port start  input  1  request to begin; accepted only in IDLE.
REQ-006 SHALL have ports busy  output 1  high from the cycle after acceptance until DONE; done  output 1  one-cycle completion pulse.
REQ-007 SHALL have ports result  output K  base^exp mod modulus; err  output 1  high when modulus==0.
REQ-008 SHALL have port div_req  output 1  one-cycle request to the external divider.
REQ-009 SHALL have ports div_a  output 2K  dividend; div_b  output 2K  divisor (modulus zero-extended).
REQ-010 SHALL have ports div_ack  input 1  divider completion pulse; div_rem  input 2K  divider remainder, valid with div_ack.

Function
REQ-011 SHALL compute left-to-right square-and-multiply: r=1, then for i=K-1 down to 0: r=r*r mod n; if exp[i], r=r*b mod n; b is base reduced mod n.
REQ-012 SHALL use FSM states IDLE, RED, SQR, MUL, NEXT, DONE.
REQ-013 IDLE with start=1 SHALL latch operands, set r=1, set bit index to K-1, and go to RED; if modulus==0, go directly to DONE with err=1 and result=0.
REQ-014 On entry to RED, SQR or MUL, the FSM SHALL drive div_req high for exactly the first cycle, then wait in that state for div_ack.
REQ-015 div_a/div_b SHALL be stable from the div_req cycle through the div_ack cycle; RED: div_a=base, SQR: div_a=r*r, MUL: div_a=r*b (full 2K-bit products, no truncation).
REQ-016 On div_ack: RED SHALL store div_rem[K-1:0] to b and go to SQR; SQR SHALL store it to r and go to MUL if exp[i]=1, else NEXT; MUL SHALL store it to r and go to NEXT.
REQ-017 NEXT SHALL go to DONE if index==0, else decrement index and go to SQR (one cycle, no divider activity).
REQ-018 DONE SHALL update result with r, pulse done for one cycle, and return to IDLE; result SHALL hold until the next accepted start.
REQ-019 Boundaries: exp=0 gives result=1 mod n; modulus=1 gives result=0; base>=modulus is handled by RED.
REQ-020 start while busy SHALL be ignored; div_ack outside a wait state SHALL be ignored.
REQ-021 Divider transaction count SHALL be 1 + K + popcount(exp) when modulus!=0 (baseline build).

Reset
REQ-022 rst low SHALL force IDLE immediately, including mid-operation.
REQ-023 rst low SHALL force busy=0, done=0, err=0, div_req=0, result=0, div_a=0, div_b=0, and the bit index to K-1.
REQ-024 After reset, a div_ack from an aborted transaction SHALL be ignored.

Configuration
REQ-025 Macro MODEXP_SKIP_LEADING_ZEROS_EN SHALL control leading-zero skipping of the exponent.
REQ-026 When defined: after RED, the FSM SHALL spend one cycle per leading zero bit of exp, decrementing the index without issuing SQR; exp=0 SHALL go straight to DONE with result=1 mod n; transaction count becomes 1 + (msb_pos+1) + popcount(exp).
REQ-027 When undefined: every one of the K bits SHALL issue SQR; result values SHALL be identical in both builds.

Verification
REQ-028 K=32, base=4, exp=13, modulus=497, behavioural divider with 3-cycle ack -> result=445, done pulse once, err=0, 1+32+3 div_req pulses (baseline).
REQ-029 Same stimulus with MODEXP_SKIP_LEADING_ZEROS_EN defined -> result=445, 1+4+3=8 div_req pulses.
REQ-030 base=1000, exp=1, modulus=7 -> RED yields 6, result=6.
REQ-031 modulus=0, any base/exp -> done the cycle after DONE entry, err=1, result=0, zero div_req pulses; exp=0, modulus=5 -> result=1.
REQ-032 rst low during the SQR wait, then spurious div_ack -> busy=0, no done pulse; a following run with base=3, exp=5, modulus=7 gives result=5.
REQ-033 start re-asserted while busy and div_ack held when not waiting -> no effect on result or transaction count.
